csa_mult_pipe: RTL and testbench
================================

Name: csa_mult_pipe

Overview:
- Parametrised pipelined carry-save array multiplier. Successor to the fixed 16-bit two-stage multiplier.
- Adds configurable width and pipeline depth, per-transaction signed/unsigned mode, and a valid/ready handshake with backpressure.
- Sits between a producer stream of operand pairs and a consumer of 2*WIDTH-bit products in datapath blocks.

Parameters:
- WIDTH, 16: operand width in bits; legal range 4..64. Product width is 2*WIDTH.
- ROWS_PER_STAGE, 4: carry-save partial-product rows per pipeline stage; legal range 1..WIDTH.
- NSTAGE (localparam), ceil(WIDTH/ROWS_PER_STAGE): number of carry-save array stages.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operand pair present.
- in_ready, output, 1: block accepts the operand pair this cycle.
- in_a, input, WIDTH: multiplicand.
- in_b, input, WIDTH: multiplier.
- in_signed, input, 1: 1 = two's-complement operands; 0 = unsigned.
- out_valid, output, 1: product present.
- out_ready, input, 1: consumer accepts the product.
- out_y, output, 2*WIDTH: product.

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits are 0, out_valid is 0, out_y is 0, and all data registers are 0. Release is synchronous to clk.
- Pipeline structure, in order:
  - Input register: a, b, signed flag.
  - NSTAGE carry-save stages. Stage k adds rows k*ROWS_PER_STAGE..min((k+1)*ROWS_PER_STAGE, WIDTH)-1. Each stage registers the retired low product bits, the running sum vector and the running carry vector.
  - One final carry-propagate adder stage, registered into out_y.
- Latency: L = NSTAGE + 2 cycles from an accepted input (in_valid & in_ready) to out_valid, with no stall. Defaults give L = 6.
- Throughput: one product per cycle when out_ready is held at 1.
- Advance rule: adv = !out_valid | out_ready. in_ready = adv. Every pipeline register, valid bits included, loads only when adv = 1; otherwise all registers hold.
  - Bubbles are not compressed: a stall freezes the whole pipe, empty slots included.
- Output stability: while out_valid = 1 and out_ready = 0, out_y is stable and out_valid stays 1.
- Valid propagation: an input accepted with in_valid = 0 inserts a bubble (valid bit 0). out_y is don't-care while out_valid = 0, but the RTL holds its last value.
- Signed mode: Baugh-Wooley form.
  - Invert the MSB partial-product bits of every row except the last.
  - Invert the non-MSB bits of the last row.
  - Add constant 1 at bit positions WIDTH and 2*WIDTH-1.
  - The signed flag travels with its data through every stage, so mixed modes back-to-back are legal.
- Unsigned mode: plain AND array, no correction. Result is exact modulo 2^(2*WIDTH).
- Boundary values:
  - Signed most-negative * most-negative gives 2^(2*WIDTH-2), with no overflow.
  - Unsigned all-ones * all-ones gives 2^(2*WIDTH) - 2^(WIDTH+1) + 1.
- Reset mid-operation: all in-flight transactions are discarded. There is no output after reset until a new input is accepted.
- Simultaneous out accept and in accept on the same cycle is the normal streaming case. No special handling.

Optional Feature:
- Macro: CSA_MULT_ACC_EN.
- With the macro defined:
  - Adds port in_acc_clr (input, 1), carried alongside its operands.
  - Adds a 2*WIDTH accumulator register after the CPA stage. out_y = (acc_clr ? 0 : acc) + product, wrapping modulo 2^(2*WIDTH).
  - The accumulator updates only when a valid product advances (adv & last-stage valid).
  - Latency is unchanged: the accumulator replaces the out_y register.
  - The accumulator resets to 0.
- Without the macro: no in_acc_clr port; out_y is the bare product.

Test Plan:
- Unsigned basic, defaults, out_ready = 1: a = 0x0003, b = 0x0005, signed = 0 → out_valid exactly 6 cycles after accept, out_y = 0x0000000F.
- Unsigned max: 0xFFFF*0xFFFF, signed = 0 → out_y = 0xFFFE0001.
- Signed corners, back-to-back:
  - 0x8000*0x8000 → 0x40000000
  - 0xFFFF*0x0002 → 0xFFFFFFFE
  - 0x7FFF*0x8000 → 0xC0008000
  - Results appear on consecutive cycles.
- Backpressure: stream 8 random pairs, hold out_ready = 0 for 5 cycles mid-stream.
  - in_ready = 0 during the hold.
  - out_y stable during the hold.
  - All 8 products delivered in order, none lost or duplicated.
- Reset mid-flight: accept 3 pairs, pulse rst_n low for 1 cycle → out_valid = 0 and out_y = 0 immediately; no stale products appear afterwards.
- Parameter sweep with CSA_MULT_ACC_EN defined:
  - WIDTH = 8, ROWS_PER_STAGE = 3 (L = 5), and WIDTH = 12, ROWS_PER_STAGE = 12 (L = 3).
  - Random signed/unsigned products checked against a reference model.
  - Accumulate 3*4, then 2*5 → 12, then 22.
  - Then acc_clr with 1*1 → 1.

Source files
------------

// File: rtl/csa_mult_pipe.sv
// csa_mult_pipe: pipelined carry-save array multiplier with valid/ready flow control.
//
// Operands pass through an input register, NSTAGE carry-save stages of
// ROWS_PER_STAGE partial-product rows each, and a final carry-propagate
// stage that drives out_y. Signed products use the Baugh-Wooley form. The
// signed flag travels with its operands, so signed and unsigned work can be
// mixed back-to-back. One global advance enable freezes the entire pipe,
// empty slots included, whenever the output is held by the consumer.
//
// Optional build macro CSA_MULT_ACC_EN: adds in_acc_clr and turns the output
// register into a 2*WIDTH accumulator (out_y = (clr ? 0 : acc) + product).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake (in_a, in_b, in_signed)
//   in_acc_clr              accumulator clear, CSA_MULT_ACC_EN builds only
//   out_valid/out_ready     product handshake (out_y, 2*WIDTH bits)

module csa_mult_pipe #(
    parameter int WIDTH          = 16,
    parameter int ROWS_PER_STAGE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
`ifdef CSA_MULT_ACC_EN
    input  logic                 in_acc_clr,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_y
);

    localparam int NSTAGE = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
    localparam int PW     = 2 * WIDTH;

    // Baugh-Wooley correction ones at bits WIDTH and 2*WIDTH-1, seeded into
    // the initial sum vector.
    localparam logic [PW-1:0] BW_CONST = ({{(PW-1){1'b0}}, 1'b1} << WIDTH) |
                                         ({{(PW-1){1'b0}}, 1'b1} << (PW-1));

    function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] a,
                                             input logic             b_bit,
                                             input logic             sgn,
                                             input int               r);
        logic [WIDTH-1:0] row;
        row = a & {WIDTH{b_bit}};
        if (sgn) begin
            if (r == WIDTH-1) row[WIDTH-2:0] = ~row[WIDTH-2:0];
            else              row[WIDTH-1]   = ~row[WIDTH-1];
        end
        return {{WIDTH{1'b0}}, row} << r;
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [WIDTH-1:0] a_in_q, b_in_q;
    logic             sg_in_q, v_in_q;
`ifdef CSA_MULT_ACC_EN
    logic             clr_in_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_in_q   <= '0;
            b_in_q   <= '0;
            sg_in_q  <= 1'b0;
            v_in_q   <= 1'b0;
`ifdef CSA_MULT_ACC_EN
            clr_in_q <= 1'b0;
`endif
        end else if (adv) begin
            a_in_q   <= in_a;
            b_in_q   <= in_b;
            sg_in_q  <= in_signed;
            v_in_q   <= in_valid;
`ifdef CSA_MULT_ACC_EN
            clr_in_q <= in_acc_clr;
`endif
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
        localparam int R_LO = k * ROWS_PER_STAGE;
        localparam int R_HI = ((k + 1) * ROWS_PER_STAGE < WIDTH) ?
                              (k + 1) * ROWS_PER_STAGE : WIDTH;

        logic [WIDTH-1:0] a_src, b_src, l_src, l_nxt, low_q;
        logic [PW-1:0]    s_src, c_src, s_nxt, c_nxt, sum_q, carry_q;
        logic             sg_src, v_src, v_q;
`ifdef CSA_MULT_ACC_EN
        logic             clr_src, clr_q;
`endif

        if (k == 0) begin : g_src
            assign a_src  = a_in_q;
            assign b_src  = b_in_q;
            assign sg_src = sg_in_q;
            assign v_src  = v_in_q;
            assign s_src  = sg_in_q ? BW_CONST : '0;
            assign c_src  = '0;
            assign l_src  = '0;
`ifdef CSA_MULT_ACC_EN
            assign clr_src = clr_in_q;
`endif
        end else begin : g_src
            assign a_src  = g_stg[k-1].g_fwd.a_q;
            assign b_src  = g_stg[k-1].g_fwd.b_q;
            assign sg_src = g_stg[k-1].g_fwd.sg_q;
            assign v_src  = g_stg[k-1].v_q;
            assign s_src  = g_stg[k-1].sum_q;
            assign c_src  = g_stg[k-1].carry_q;
            assign l_src  = g_stg[k-1].low_q;
`ifdef CSA_MULT_ACC_EN
            assign clr_src = g_stg[k-1].clr_q;
`endif
        end

        // After row r the carry vector is zero at bits <= r and later rows
        // start at bit r+1, so sum bit r is final and retires into low.
        always_comb begin
            logic [PW-1:0] pp, maj;
            pp    = '0;
            maj   = '0;
            s_nxt = s_src;
            c_nxt = c_src;
            l_nxt = l_src;
            for (int r = R_LO; r < R_HI; r++) begin
                pp       = pp_row(a_src, b_src[r], sg_src, r);
                maj      = (s_nxt & c_nxt) | (s_nxt & pp) | (c_nxt & pp);
                s_nxt    = s_nxt ^ c_nxt ^ pp;
                c_nxt    = maj << 1;
                l_nxt[r] = s_nxt[r];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= '0;
                low_q   <= '0;
                v_q     <= 1'b0;
`ifdef CSA_MULT_ACC_EN
                clr_q   <= 1'b0;
`endif
            end else if (adv) begin
                sum_q   <= s_nxt;
                carry_q <= c_nxt;
                low_q   <= l_nxt;
                v_q     <= v_src;
`ifdef CSA_MULT_ACC_EN
                clr_q   <= clr_src;
`endif
            end
        end

        // Operands are only needed by stages that still have rows to add.
        if (k < NSTAGE - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q, b_q;
            logic             sg_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    sg_q <= 1'b0;
                end else if (adv) begin
                    a_q  <= a_src;
                    b_q  <= b_src;
                    sg_q <= sg_src;
                end
            end
        end
    end

    // Low half is already resolved; only the upper half needs a carry chain.
    logic [PW-1:0] prod;
    assign prod = {g_stg[NSTAGE-1].sum_q[PW-1:WIDTH] + g_stg[NSTAGE-1].carry_q[PW-1:WIDTH],
                   g_stg[NSTAGE-1].low_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
        end else if (adv) begin
            out_valid <= g_stg[NSTAGE-1].v_q;
            if (g_stg[NSTAGE-1].v_q) begin
`ifdef CSA_MULT_ACC_EN
                out_y <= (g_stg[NSTAGE-1].clr_q ? '0 : out_y) + prod;
`else
                out_y <= prod;
`endif
            end
        end
    end

endmodule

// File: tb/tb_csa_mult_pipe.sv
module tb_csa_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_signed = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_y;
`ifdef CSA_MULT_ACC_EN
    logic        in_acc_clr = 1'b1;
`endif

    always #5 clk = ~clk;

    csa_mult_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
`ifdef CSA_MULT_ACC_EN
        .in_acc_clr(in_acc_clr),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    int npass = 0;
    int ntot  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] mul_ref(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic s);
        logic [63:0] wm, ax, bx;
        wm = (64'd1 << w) - 64'd1;
        ax = a & wm;
        bx = b & wm;
        if (s && ax[w-1]) ax = ax | ~wm;
        if (s && bx[w-1]) bx = bx | ~wm;
        return (ax * bx) & ((64'd1 << (2*w)) - 64'd1);
    endfunction

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vs [8];
    logic [31:0] ve [8];

    // Drives n operand pairs from va/vb/vs, holds out_ready low for hold_len
    // cycles starting at cycle hold_at, and checks products against ve.
    task automatic stream(input string tag, input int n, input int hold_at,
                          input int hold_len);
        int sent = 0, got = 0, first_acc = -1, first_out = -1, last_out = -1, extra = 0;
        logic [31:0] held = '0;
        for (int c = 0; c < 200 && got < n; c++) begin
            logic hold;
            hold      = (c >= hold_at) && (c < hold_at + hold_len);
            in_valid  = (sent < n);
            in_a      = (sent < n) ? va[sent] : 16'h0;
            in_b      = (sent < n) ? vb[sent] : 16'h0;
            in_signed = (sent < n) ? vs[sent] : 1'b0;
            out_ready = !hold;
            #1;
            if (hold) begin
                check({tag, "_in_ready_hold"}, 64'(in_ready), 64'd0);
                check({tag, "_out_valid_hold"}, 64'(out_valid), 64'd1);
                if (c == hold_at) held = out_y;
                else check({tag, "_out_y_stable"}, 64'(out_y), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (got < n) check($sformatf("%s_y%0d", tag, got), 64'(out_y), 64'(ve[got]));
                if (first_out < 0) first_out = c;
                last_out = c;
                got++;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = c;
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, 64'(got), 64'(n));
        check({tag, "_latency"}, 64'(first_out - first_acc), 64'd6);
        if (hold_len == 0 && n > 1)
            check({tag, "_consecutive"}, 64'(last_out - first_out), 64'(n - 1));
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) extra++;
            @(posedge clk);
            #1;
        end
        check({tag, "_no_extra"}, 64'(extra), 64'd0);
    endtask

`ifdef CSA_MULT_ACC_EN
    logic        sw_valid = 1'b0, sw_s = 1'b0, sw_clr = 1'b0, sw_oready = 1'b1;
    logic [11:0] sw_a = '0, sw_b = '0;
    logic        r8, ov8, r12, ov12;
    logic [15:0] y8;
    logic [23:0] y12;

    csa_mult_pipe #(.WIDTH(8), .ROWS_PER_STAGE(3)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r8),
        .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_signed(sw_s), .in_acc_clr(sw_clr),
        .out_valid(ov8), .out_ready(sw_oready), .out_y(y8));

    csa_mult_pipe #(.WIDTH(12), .ROWS_PER_STAGE(12)) u12 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r12),
        .in_a(sw_a), .in_b(sw_b), .in_signed(sw_s), .in_acc_clr(sw_clr),
        .out_valid(ov12), .out_ready(sw_oready), .out_y(y12));

    logic [11:0] sa [11];
    logic [11:0] sb [11];
    logic        ss [11];
    logic        sc [11];
    logic [63:0] e8 [11];
    logic [63:0] e12 [11];

    task automatic sweep(input int n);
        int g8 = 0, g12 = 0, fo8 = -1, fo12 = -1;
        for (int c = 0; c < n + 20; c++) begin
            sw_valid = (c < n);
            sw_a     = (c < n) ? sa[c] : 12'h0;
            sw_b     = (c < n) ? sb[c] : 12'h0;
            sw_s     = (c < n) ? ss[c] : 1'b0;
            sw_clr   = (c < n) ? sc[c] : 1'b0;
            #1;
            if (ov8) begin
                if (g8 < n) check($sformatf("w8_y%0d", g8), 64'(y8), e8[g8]);
                if (fo8 < 0) fo8 = c;
                g8++;
            end
            if (ov12) begin
                if (g12 < n) check($sformatf("w12_y%0d", g12), 64'(y12), e12[g12]);
                if (fo12 < 0) fo12 = c;
                g12++;
            end
            @(posedge clk);
            #1;
        end
        sw_valid = 1'b0;
        check("w8_count", 64'(g8), 64'(n));
        check("w12_count", 64'(g12), 64'(n));
        check("w8_latency", 64'(fo8), 64'd5);
        check("w12_latency", 64'(fo12), 64'd3);
    endtask
`endif

    initial begin
        int extra;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        va[0] = 16'h0003; vb[0] = 16'h0005; vs[0] = 1'b0; ve[0] = 32'h0000000F;
        stream("ubasic", 1, 1000, 0);

        va[0] = 16'h8000; vb[0] = 16'h8000; vs[0] = 1'b1; ve[0] = 32'h40000000;
        va[1] = 16'hFFFF; vb[1] = 16'h0002; vs[1] = 1'b1; ve[1] = 32'hFFFFFFFE;
        va[2] = 16'h7FFF; vb[2] = 16'h8000; vs[2] = 1'b1; ve[2] = 32'hC0008000;
        stream("signed", 3, 1000, 0);

        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vs[i] = 1'($urandom);
            ve[i] = 32'(mul_ref(16, 64'(va[i]), 64'(vb[i]), vs[i]));
        end
        stream("bp", 8, 7, 5);

        va[0] = 16'hFFFF; vb[0] = 16'hFFFF; vs[0] = 1'b0; ve[0] = 32'hFFFE0001;
        stream("umax", 1, 1000, 0);

        for (int c = 0; c < 3; c++) begin
            in_valid  = 1'b1;
            in_a      = 16'(c + 2);
            in_b      = 16'h0011;
            in_signed = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_y", 64'(out_y), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_valid) extra++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_stale", 64'(extra), 64'd0);

        va[0] = 16'h0007; vb[0] = 16'h0009; vs[0] = 1'b0; ve[0] = 32'h0000003F;
        stream("postrst", 1, 1000, 0);

`ifdef CSA_MULT_ACC_EN
        begin
            logic [63:0] acc8, acc12;
            acc8  = '0;
            acc12 = '0;
            for (int i = 0; i < 8; i++) begin
                sa[i] = 12'($urandom);
                sb[i] = 12'($urandom);
                ss[i] = 1'($urandom);
                sc[i] = 1'b1;
            end
            sa[8] = 12'd3; sb[8] = 12'd4; ss[8] = 1'b0; sc[8] = 1'b1;
            sa[9] = 12'd2; sb[9] = 12'd5; ss[9] = 1'b0; sc[9] = 1'b0;
            sa[10] = 12'd1; sb[10] = 12'd1; ss[10] = 1'b0; sc[10] = 1'b1;
            for (int i = 0; i < 11; i++) begin
                acc8   = ((sc[i] ? 64'd0 : acc8) + mul_ref(8, 64'(sa[i]), 64'(sb[i]), ss[i])) & 64'hFFFF;
                acc12  = ((sc[i] ? 64'd0 : acc12) + mul_ref(12, 64'(sa[i]), 64'(sb[i]), ss[i])) & 64'hFFFFFF;
                e8[i]  = acc8;
                e12[i] = acc12;
            end
            e8[8] = 64'd12; e8[9] = 64'd22; e8[10] = 64'd1;
            e12[8] = 64'd12; e12[9] = 64'd22; e12[10] = 64'd1;
            sweep(11);
        end
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
